// File: rtl/y86_pkg.sv
// Shared y86 decode/writeback definitions: icodes, register ids, FSM states and the field decode map.
package y86_pkg;

  localparam int Y86_DW   = 32;
  localparam int Y86_NREG = 8;
  localparam int Y86_RW   = 3;

  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RESP  = 4'h4;

  typedef enum logic [2:0] {IDLE, WAIT, READ, CAPT, OUT} dec_state_t;
  typedef enum logic [1:0] {WB_IDLE, WB_E, WB_M} wb_state_t;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_fields_t;

  // Unused sources stay RNONE internally so they never raise a hazard; the port drives index 0.
  function automatic dec_fields_t decode_fields(input logic [3:0] icode, input logic [3:0] ra,
                                                input logic [3:0] rb);
    dec_fields_t f;
    f = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      IRRMOVL: begin f.src_a = ra; f.dst_e = rb; end
      IIRMOVL: f.dst_e = rb;
      IRMMOVL: begin f.src_a = ra; f.src_b = rb; end
      IMRMOVL: begin f.src_b = rb; f.dst_m = ra; end
      IOPL:    begin f.src_a = ra; f.src_b = rb; f.dst_e = rb; end
      IJXX:    ;
      ICALL:   begin f.src_b = RESP; f.dst_e = RESP; end
      IRET:    begin f.src_a = RESP; f.src_b = RESP; f.dst_e = RESP; end
      IPUSHL:  begin f.src_a = ra; f.src_b = RESP; f.dst_e = RESP; end
      IPOPL:   begin f.src_a = RESP; f.src_b = RESP; f.dst_e = RESP; f.dst_m = ra; end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/y86_decode_wb_if.sv
// Bus bundle between the y86 decode/writeback block and its neighbours (decoder, regfile, execute, WB).
interface y86_decode_wb_if #(
  parameter int DW = 32,
  parameter int RW = 3
);
  logic          in_valid, in_ready;
  logic [3:0]    in_icode, in_rA, in_rB;
  logic [DW-1:0] in_valC;
  logic [RW-1:0] srcA, srcB;
  logic [DW-1:0] valA, valB;
  logic          e_valid, e_ready;
  logic [3:0]    e_icode, e_dstE, e_dstM;
  logic [DW-1:0] e_valA, e_valB, e_valC;
  logic          w_valid, w_ready;
  logic [3:0]    w_dstE, w_dstM;
  logic [DW-1:0] w_valE, w_valM;
  logic [RW-1:0] dstW;
  logic [DW-1:0] valE;
  logic          Write;

  modport master (
    output in_valid, in_icode, in_rA, in_rB, in_valC, valA, valB, e_ready,
           w_valid, w_dstE, w_valE, w_dstM, w_valM,
    input  in_ready, srcA, srcB, e_valid, e_icode, e_valA, e_valB, e_valC, e_dstE, e_dstM,
           w_ready, dstW, valE, Write
  );

  modport slave (
    input  in_valid, in_icode, in_rA, in_rB, in_valC, valA, valB, e_ready,
           w_valid, w_dstE, w_valE, w_dstM, w_valM,
    output in_ready, srcA, srcB, e_valid, e_icode, e_valA, e_valB, e_valC, e_dstE, e_dstM,
           w_ready, dstW, valE, Write
  );
endinterface

// File: rtl/y86_scoreboard.sv
// Per-register busy bits: set by issued destinations, cleared by committed writes, set wins on a tie.
module y86_scoreboard
  import y86_pkg::*;
#(
  parameter int NREG = Y86_NREG,
  parameter int RW   = Y86_RW
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [3:0]    set_a,
  input  logic [3:0]    set_b,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  dec_fields_t   query,
  output logic          hazard
);

  logic [NREG-1:0] busy, set_mask, clr_mask, query_mask;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] r);
    logic [NREG-1:0] m;
    m = '0;
    if (r != RNONE) m[r[RW-1:0]] = 1'b1;
    return m;
  endfunction

  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  assign set_mask   = onehot(set_a) | onehot(set_b);
  assign query_mask = onehot(query.src_a) | onehot(query.src_b) |
                      onehot(query.dst_e) | onehot(query.dst_m);
  assign hazard     = |(busy & query_mask);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/y86_decode_wb.sv
// y86 decode/writeback: hazard-checked operand fetch to execute, and serialised regfile writeback.
// States: IDLE accept | WAIT hazard | READ srcs held | CAPT latch vals | OUT offer bundle; WB_IDLE | WB_E | WB_M.
// Define Y86_WB_TRACE_EN to print every committed regfile write.
module y86_decode_wb
  import y86_pkg::*;
#(
  parameter int DW   = Y86_DW,
  parameter int NREG = Y86_NREG,
  parameter int RW   = Y86_RW
) (
  input logic            CLK,
  input logic            reset,
  y86_decode_wb_if.slave bus
);

  dec_state_t    d_state, d_next;
  wb_state_t     w_state, w_next;
  dec_fields_t   dec_in, fld, query;
  logic [3:0]    f_icode, set_a, set_b, wf_dstm;
  logic [DW-1:0] f_valc, f_vala, f_valb, wf_valm;
  logic          hazard, accept_d, accept_w, wf_same, clr_en;
  logic          write_q, write_n;
  logic [RW-1:0] dstw_q, dstw_n;
  logic [DW-1:0] vale_q, vale_n;

  assign dec_in   = decode_fields(bus.in_icode, bus.in_rA, bus.in_rB);
  assign query    = (d_state == IDLE) ? dec_in : fld;
  assign accept_d = (d_state == IDLE) && bus.in_valid;
  assign accept_w = (w_state == WB_IDLE) && bus.w_valid;

  always_comb begin
    d_next = d_state;
    case (d_state)
      IDLE:    if (bus.in_valid) d_next = hazard ? WAIT : READ;
      WAIT:    if (!hazard) d_next = READ;
      READ:    d_next = CAPT;
      CAPT:    d_next = OUT;
      OUT:     if (bus.e_ready) d_next = IDLE;
      default: d_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) d_state <= IDLE;
    else        d_state <= d_next;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fld     <= '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
      f_icode <= '0;
      f_valc  <= '0;
      f_vala  <= '0;
      f_valb  <= '0;
    end else begin
      if (accept_d) begin
        fld     <= dec_in;
        f_icode <= bus.in_icode;
        f_valc  <= bus.in_valC;
      end
      if (d_state == CAPT) begin
        f_vala <= bus.valA;
        f_valb <= bus.valB;
      end
    end
  end

  assign bus.in_ready = (d_state == IDLE);
  assign bus.srcA     = (d_state == READ && fld.src_a != RNONE) ? fld.src_a[RW-1:0] : '0;
  assign bus.srcB     = (d_state == READ && fld.src_b != RNONE) ? fld.src_b[RW-1:0] : '0;
  assign bus.e_valid  = (d_state == OUT);
  assign bus.e_icode  = f_icode;
  assign bus.e_valA   = f_vala;
  assign bus.e_valB   = f_valb;
  assign bus.e_valC   = f_valc;
  assign bus.e_dstE   = fld.dst_e;
  assign bus.e_dstM   = fld.dst_m;

  always_comb begin
    w_next  = w_state;
    write_n = 1'b0;
    dstw_n  = dstw_q;
    vale_n  = vale_q;
    case (w_state)
      WB_IDLE: if (bus.w_valid) begin
        w_next  = WB_E;
        write_n = (bus.w_dstE != RNONE);
        dstw_n  = bus.w_dstE[RW-1:0];
        vale_n  = bus.w_valE;
      end
      WB_E: if (wf_dstm != RNONE) begin
        w_next  = WB_M;
        write_n = 1'b1;
        dstw_n  = wf_dstm[RW-1:0];
        vale_n  = wf_valm;
      end else begin
        w_next = WB_IDLE;
      end
      WB_M:    w_next = WB_IDLE;
      default: w_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      w_state <= WB_IDLE;
      write_q <= 1'b0;
      dstw_q  <= '0;
      vale_q  <= '0;
      wf_dstm <= RNONE;
      wf_valm <= '0;
      wf_same <= 1'b0;
    end else begin
      w_state <= w_next;
      write_q <= write_n;
      dstw_q  <= dstw_n;
      vale_q  <= vale_n;
      if (accept_w) begin
        wf_dstm <= bus.w_dstM;
        wf_valm <= bus.w_valM;
        wf_same <= (bus.w_dstE == bus.w_dstM);
      end
    end
  end

  assign bus.w_ready = (w_state == WB_IDLE);
  assign bus.Write   = write_q;
  assign bus.dstW    = dstw_q;
  assign bus.valE    = vale_q;

  // When E and M target the same register the index stays busy until the M write lands.
  assign clr_en = write_q && !(w_state == WB_E && wf_same);
  assign set_a  = (d_state == CAPT) ? fld.dst_e : RNONE;
  assign set_b  = (d_state == CAPT) ? fld.dst_m : RNONE;

  y86_scoreboard #(.NREG(NREG), .RW(RW)) u_scoreboard (
    .CLK     (CLK),
    .reset   (reset),
    .set_a   (set_a),
    .set_b   (set_b),
    .clr_en  (clr_en),
    .clr_idx (dstw_q),
    .query   (query),
    .hazard  (hazard)
  );

`ifdef Y86_WB_TRACE_EN
  always_ff @(posedge CLK) begin
    if (write_q) $display("wb r%0d = %h", dstw_q, vale_q);
  end
`else
  // silent build: no trace output
`endif

endmodule
